// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (m0) and the data port (m1). Grants are combinational (zero-latency when
// idle), conflicts are settled round-robin, and read data is steered back to
// the requester that issued the read exactly MEM_LAT cycles after its grant.
// MEM_LAT must lie in 1..7 and DATA_W must be a multiple of 8.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction-fetch requester
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DATA_W/8-1:0]   m0_be,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    // data requester
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    // shared memory
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    // A read keeps the memory busy for MEM_LAT cycles; the counter covers the
    // cycles after the grant cycle.
    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic              owner_q;     // requester whose read is outstanding
    logic              last_q;      // last granted requester
    logic [2:0]        cnt_q;       // remaining read-latency cycles
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;

    logic              grant_ok;
    logic              m0_gnt_d;
    logic              m1_gnt_d;
    logic              any_gnt;
    logic              win_sel;     // 1 when m1 wins this cycle
    logic              win_we;

    logic              mem_en_d;
    logic              mem_we_d;
    logic [BE_W-1:0]   mem_be_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // Round-robin arbitration: a lone requester wins, on a tie the one that was
    // not granted last wins. Grants are held off while reset is asserted so
    // every output reads zero during reset.
    always_comb begin
        grant_ok = rst_n && (state_q == ST_IDLE);
        m0_gnt_d = grant_ok && m0_req && (!m1_req || last_q);
        m1_gnt_d = grant_ok && m1_req && (!m0_req || !last_q);
        any_gnt  = m0_gnt_d || m1_gnt_d;
        win_sel  = m1_gnt_d;
        win_we   = m1_gnt_d ? m1_we : m0_we;
    end

    // Memory bus: carries the winner's fields during a grant, all zero otherwise.
    always_comb begin
        mem_en_d    = any_gnt;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (m1_gnt_d) begin
            mem_we_d    = m1_we;
            mem_be_d    = m1_be;
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
        end else if (m0_gnt_d) begin
            mem_we_d    = m0_we;
            mem_be_d    = m0_be;
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
        end
    end

    // Sequencer: tracks the outstanding read and raises the owner's rvalid in
    // the cycle the memory returns data (the FSM is back in IDLE by then, so a
    // new grant can overlap the return).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= 3'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_gnt) begin
                        last_q <= win_sel;
                        if (!win_we) begin
                            owner_q <= win_sel;
                            cnt_q   <= CNT_INIT;
                            if (MEM_LAT == 1) begin
                                m0_rvalid_q <= !win_sel;
                                m1_rvalid_q <= win_sel;
                            end else begin
                                state_q <= ST_RD_WAIT;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q     <= ST_IDLE;
                        m0_rvalid_q <= !owner_q;
                        m1_rvalid_q <= owner_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt    = m0_gnt_d;
    assign m1_gnt    = m1_gnt_d;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;

    // Return data reaches only the port whose rvalid is up; the other sees zero.
    assign m0_rdata  = m0_rvalid_q ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid_q ? mem_rdata : '0;

    assign mem_en    = mem_en_d;
    assign mem_we    = mem_we_d;
    assign mem_be    = mem_be_d;
    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each
// backed by a small behavioural memory. Table of per-cycle vectors on the
// MEM_LAT=1 instance, hand-written sequences for the multi-cycle cases.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        v0;
        logic        v1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct packed {
        req_t r0;
        req_t r1;
        exp_t e;
    } vec_t;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam req_t NOREQ = '0;
    localparam exp_t ZERO  = '0;
    localparam int   NVEC  = 13;

    logic        clk;
    logic        rst_n;
    logic        m0_req [3];
    logic        m0_we [3];
    logic [3:0]  m0_be [3];
    logic [31:0] m0_addr [3];
    logic [31:0] m0_wdata [3];
    logic        m0_gnt [3];
    logic        m0_rvalid [3];
    logic [31:0] m0_rdata [3];
    logic        m1_req [3];
    logic        m1_we [3];
    logic [3:0]  m1_be [3];
    logic [31:0] m1_addr [3];
    logic [31:0] m1_wdata [3];
    logic        m1_gnt [3];
    logic        m1_rvalid [3];
    logic [31:0] m1_rdata [3];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [3:0]  mem_be [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as a recognisable address-derived pattern.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        logic [31:0]  mem [256];
        logic [255:0] wr_ok;
        logic [31:0]  pipe [gi+1];
        logic [31:0]  rword;

        assign rword = wr_ok[mem_addr[gi][7:0]] ? mem[mem_addr[gi][7:0]] : dflt(mem_addr[gi]);
        assign mem_rdata[gi] = pipe[gi];

        // Memory model: byte-enabled write, read data after gi+1 cycles, zero otherwise.
        always @(posedge clk) begin
            if (!rst_n) begin
                wr_ok <= '0;
            end else if (mem_en[gi] && mem_we[gi]) begin
                mem[mem_addr[gi][7:0]]   <= merge(rword, mem_wdata[gi], mem_be[gi]);
                wr_ok[mem_addr[gi][7:0]] <= 1'b1;
            end
            pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? rword : 32'h0;
            for (int s = 1; s <= gi; s++) pipe[s] <= pipe[s-1];
        end

        mem_port_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .MEM_LAT(gi + 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .m0_req   (m0_req[gi]),
            .m0_we    (m0_we[gi]),
            .m0_be    (m0_be[gi]),
            .m0_addr  (m0_addr[gi]),
            .m0_wdata (m0_wdata[gi]),
            .m0_gnt   (m0_gnt[gi]),
            .m0_rvalid(m0_rvalid[gi]),
            .m0_rdata (m0_rdata[gi]),
            .m1_req   (m1_req[gi]),
            .m1_we    (m1_we[gi]),
            .m1_be    (m1_be[gi]),
            .m1_addr  (m1_addr[gi]),
            .m1_wdata (m1_wdata[gi]),
            .m1_gnt   (m1_gnt[gi]),
            .m1_rvalid(m1_rvalid[gi]),
            .m1_rdata (m1_rdata[gi]),
            .mem_en   (mem_en[gi]),
            .mem_we   (mem_we[gi]),
            .mem_be   (mem_be[gi]),
            .mem_addr (mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]),
            .mem_rdata(mem_rdata[gi])
        );
    end

    function automatic req_t rd(input logic [31:0] a, input logic [3:0] b);
        return '{req: 1'b1, we: 1'b0, be: b, addr: a, wdata: 32'h0};
    endfunction

    function automatic req_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        return '{req: 1'b1, we: 1'b1, be: b, addr: a, wdata: d};
    endfunction

    // Expected outputs; m is the request that must appear on the memory bus.
    function automatic exp_t ex(input logic g0, input logic g1, input logic v0, input logic v1,
                                input logic [31:0] r0d, input logic [31:0] r1d, input req_t m);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.v0 = v0; e.v1 = v1;
        e.rd0 = r0d; e.rd1 = r1d;
        e.en = m.req; e.we = m.we; e.be = m.be; e.addr = m.addr; e.wdata = m.wdata;
        return e;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h, want %h", tag, fld, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input string fld, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %b, want %b", tag, fld, act, exp);
        end
    endtask

    task automatic chk_out(input int k, input string tag, input exp_t e);
        chk1(tag, "m0_gnt",    m0_gnt[k],    e.g0);
        chk1(tag, "m1_gnt",    m1_gnt[k],    e.g1);
        chk1(tag, "m0_rvalid", m0_rvalid[k], e.v0);
        chk1(tag, "m1_rvalid", m1_rvalid[k], e.v1);
        chk(tag,  "m0_rdata",  m0_rdata[k],  e.rd0);
        chk(tag,  "m1_rdata",  m1_rdata[k],  e.rd1);
        chk1(tag, "mem_en",    mem_en[k],    e.en);
        chk1(tag, "mem_we",    mem_we[k],    e.we);
        chk(tag,  "mem_be",    {28'h0, mem_be[k]}, {28'h0, e.be});
        chk(tag,  "mem_addr",  mem_addr[k],  e.addr);
        chk(tag,  "mem_wdata", mem_wdata[k], e.wdata);
        $display("%0t inst%0d %s: gnt=%b%b rvalid=%b%b en=%b addr=%h", $time, k, tag,
                 m1_gnt[k], m0_gnt[k], m1_rvalid[k], m0_rvalid[k], mem_en[k], mem_addr[k]);
    endtask

    task automatic drive(input int k, input req_t r0, input req_t r1);
        m0_req[k] = r0.req; m0_we[k] = r0.we; m0_be[k] = r0.be;
        m0_addr[k] = r0.addr; m0_wdata[k] = r0.wdata;
        m1_req[k] = r1.req; m1_we[k] = r1.we; m1_be[k] = r1.be;
        m1_addr[k] = r1.addr; m1_wdata[k] = r1.wdata;
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input int k, input logic rst, input req_t r0, input req_t r1,
                        input exp_t e, input string tag);
        @(posedge clk);
        #1;
        rst_n = rst;
        drive(k, r0, r1);
        @(negedge clk);
        chk_out(k, tag, e);
    endtask

    vec_t tbl [NVEC];

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Cycle-by-cycle vectors for the MEM_LAT=1 instance.
        tbl[0]  = '{rd(32'h20, 4'hF), wr(32'h10, 32'hDEADBEEF, 4'hF),
                    ex(N, Y, N, N, 32'h0, 32'h0, wr(32'h10, 32'hDEADBEEF, 4'hF))};
        tbl[1]  = '{rd(32'h20, 4'hF), NOREQ,
                    ex(Y, N, N, N, 32'h0, 32'h0, rd(32'h20, 4'hF))};
        tbl[2]  = '{NOREQ, rd(32'h10, 4'h1),
                    ex(N, Y, Y, N, 32'hA5000020, 32'h0, rd(32'h10, 4'h1))};
        tbl[3]  = '{NOREQ, NOREQ,
                    ex(N, N, N, Y, 32'h0, 32'hDEADBEEF, NOREQ)};
        tbl[4]  = '{wr(32'h30, 32'h12345678, 4'h3), NOREQ,
                    ex(Y, N, N, N, 32'h0, 32'h0, wr(32'h30, 32'h12345678, 4'h3))};
        tbl[5]  = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(N, Y, N, N, 32'h0, 32'h0, rd(32'h10, 4'hF))};
        tbl[6]  = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(Y, N, N, Y, 32'h0, 32'hDEADBEEF, rd(32'h30, 4'hF))};
        tbl[7]  = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(N, Y, Y, N, 32'hA5005678, 32'h0, rd(32'h10, 4'hF))};
        tbl[8]  = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(Y, N, N, Y, 32'h0, 32'hDEADBEEF, rd(32'h30, 4'hF))};
        tbl[9]  = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(N, Y, Y, N, 32'hA5005678, 32'h0, rd(32'h10, 4'hF))};
        tbl[10] = '{rd(32'h30, 4'hF), rd(32'h10, 4'hF),
                    ex(Y, N, N, Y, 32'h0, 32'hDEADBEEF, rd(32'h30, 4'hF))};
        tbl[11] = '{NOREQ, NOREQ,
                    ex(N, N, Y, N, 32'hA5005678, 32'h0, NOREQ)};
        tbl[12] = '{NOREQ, NOREQ, ZERO};

        // Reset with both requesters active on every instance.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, tbl[0].r0, tbl[0].r1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_out(k, "reset", ZERO);

        // Release: the first conflict goes to m1.
        @(posedge clk);
        #1;
        drive(1, NOREQ, NOREQ);
        drive(2, NOREQ, NOREQ);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out(0, "vec0", tbl[0].e);
        for (int i = 1; i < NVEC; i++)
            step(0, 1'b1, tbl[i].r0, tbl[i].r1, tbl[i].e, $sformatf("vec%0d", i));

        // MEM_LAT=2: write then read back-to-back, plus a request stalled by the read.
        step(1, 1'b1, rd(32'h80, 4'hF), wr(32'h80, 32'h0BADF00D, 4'hF),
             ex(N, Y, N, N, 32'h0, 32'h0, wr(32'h80, 32'h0BADF00D, 4'hF)), "l2_wr");
        step(1, 1'b1, rd(32'h80, 4'hF), NOREQ,
             ex(Y, N, N, N, 32'h0, 32'h0, rd(32'h80, 4'hF)), "l2_rd");
        step(1, 1'b1, NOREQ, rd(32'h80, 4'hF), ZERO, "l2_wait");
        step(1, 1'b1, NOREQ, rd(32'h80, 4'hF),
             ex(N, Y, Y, N, 32'h0BADF00D, 32'h0, rd(32'h80, 4'hF)), "l2_ret");
        step(1, 1'b1, NOREQ, NOREQ, ZERO, "l2_gap");
        step(1, 1'b1, NOREQ, NOREQ, ex(N, N, N, Y, 32'h0, 32'h0BADF00D, NOREQ), "l2_ret1");
        step(1, 1'b1, NOREQ, NOREQ, ZERO, "l2_idle");

        // MEM_LAT=3: m1 stalls for two cycles behind an m0 read.
        step(2, 1'b1, rd(32'h40, 4'hF), NOREQ,
             ex(Y, N, N, N, 32'h0, 32'h0, rd(32'h40, 4'hF)), "l3_t0");
        step(2, 1'b1, NOREQ, rd(32'h50, 4'hF), ZERO, "l3_t1");
        step(2, 1'b1, NOREQ, rd(32'h50, 4'hF), ZERO, "l3_t2");
        step(2, 1'b1, NOREQ, rd(32'h50, 4'hF),
             ex(N, Y, Y, N, 32'hA5000040, 32'h0, rd(32'h50, 4'hF)), "l3_t3");
        step(2, 1'b1, NOREQ, NOREQ, ZERO, "l3_t4");
        step(2, 1'b1, NOREQ, NOREQ, ZERO, "l3_t5");
        step(2, 1'b1, NOREQ, NOREQ, ex(N, N, N, Y, 32'h0, 32'hA5000050, NOREQ), "l3_t6");

        // MEM_LAT=3: reset during an outstanding read discards its return.
        step(2, 1'b1, rd(32'h60, 4'hF), NOREQ,
             ex(Y, N, N, N, 32'h0, 32'h0, rd(32'h60, 4'hF)), "rst_t0");
        step(2, 1'b0, NOREQ, NOREQ, ZERO, "rst_t1");
        step(2, 1'b1, NOREQ, rd(32'h70, 4'hF),
             ex(N, Y, N, N, 32'h0, 32'h0, rd(32'h70, 4'hF)), "rst_t2");
        step(2, 1'b1, NOREQ, NOREQ, ZERO, "rst_t3");
        step(2, 1'b1, NOREQ, NOREQ, ZERO, "rst_t4");
        step(2, 1'b1, NOREQ, NOREQ, ex(N, N, N, Y, 32'h0, 32'hA5000070, NOREQ), "rst_t5");
        step(2, 1'b1, NOREQ, NOREQ, ZERO, "rst_t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, fixed-latency memory between the core's instruction-fetch port (M0) and data port (M1). It sits between the core and a unified IMEM/DMEM array so a single memory macro can back both paths. It provides grant, read-return and busy sequencing, and uses round-robin priority on conflicts. The core stalls on a missing `gnt` or a pending `rvalid`.

## Interface
- `ADDR_W`, default 32: address width
- `DATA_W`, default 32: data width; must be a multiple of 8
- `MEM_LAT`, default 1: memory read latency in cycles; legal range 1..7

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `m0_req`  in  1  M0 request
- `m0_we`  in  1  M0 write enable
- `m0_be`  in  DATA_W/8  M0 byte enables
- `m0_addr`  in  ADDR_W  M0 address
- `m0_wdata`  in  DATA_W  M0 write data
- `m0_gnt`  out  1  M0 request accepted this cycle
- `m0_rvalid`  out  1  M0 read data valid
- `m0_rdata`  out  DATA_W  M0 read data
- `m1_*`  same set as M0, for the data port
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after a read `mem_en`

## Operation
- **States:** IDLE and RD_WAIT. Registers:
  - `owner` (1b): requester whose read is outstanding.
  - `last` (1b): last granted requester.
  - `cnt` (3b): read-latency counter.
- **Requester rules:**
  - A requester holds `req` and all request fields stable until it sees `gnt`.
  - `gnt` is a 1-cycle pulse per accepted request.
- **Grant in IDLE (combinational):**
  - One requester active: grant it.
  - Both active: grant the one ≠ `last`.
  - On a grant, `mem_*` is driven from the winner's fields with `mem_en=1`, and `last` is updated to the winner.
- **Write grant:**
  - Completes in the grant cycle; no `rvalid` is generated.
  - FSM stays in IDLE, so back-to-back writes run at 1 per cycle.
- **Read grant:**
  - Sets `owner` and loads `cnt=MEM_LAT-1`.
  - If MEM_LAT=1, FSM stays in IDLE. Otherwise it goes to RD_WAIT.
- **RD_WAIT:**
  - No grants are issued and `mem_en=0`.
  - `cnt` decrements each cycle. When `cnt==1`, FSM returns to IDLE next cycle.
- **Read return:**
  - In cycle T+MEM_LAT after a read granted in cycle T, `m<owner>_rvalid=1` and `m<owner>_rdata=mem_rdata`.
  - A new grant is legal in that same cycle (return overlaps the next issue).
- **`rdata` on the non-owner port:** zero.
- **`mem_*` when `mem_en=0`:** `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are driven to zero.
- **Unused bytes:** `m*_be` is passed through unchanged. Reads ignore `be` (the full word is returned).

## Timing
- **Reset values:**
  - All outputs 0.
  - `owner=0`, `last=0`, `cnt=0`, FSM=IDLE.
  - First conflict goes to M1 (`last=0` ⇒ M1 wins).
- **Grant latency:** 0 cycles when idle, i.e. `gnt` is asserted in the same cycle as `req`.
- **Read occupancy:** MEM_LAT cycles. Sustained read throughput is 1 per MEM_LAT cycles.
- **Write occupancy:** 1 cycle.
- **Simultaneous requests:** alternate strictly under continuous contention: M1, M0, M1, …
- **Request arriving during RD_WAIT:** stalls (`gnt=0`) until the cycle the pending read's `rvalid` fires, then is granted in that cycle.
- **`rvalid`:** exactly one pulse per granted read, never for writes, never on both ports in one cycle.
- **Reset asserted mid-read:** outstanding read is discarded; no `rvalid` after reset release; FSM=IDLE.
- **`req` dropped without grant:** illegal (protocol violation); behaviour is undefined and is not checked.

## Test plan
- **Reset:** hold `rst_n=0` with `m0_req=m1_req=1`.
  - Required: all outputs 0.
  - Release; first cycle gives `m1_gnt=1`, `mem_addr=m1_addr`.
- **Single write, MEM_LAT=1:** M1 write, `addr=0x10`, `wdata=0xDEADBEEF`, `be=4'hF`.
  - Required: same-cycle `m1_gnt`, `mem_en=1`, `mem_we=1`, no `rvalid`.
  - A following M1 read of 0x10 returns `0xDEADBEEF` with `m1_rvalid` one cycle later.
- **Contention, MEM_LAT=1:** M0 and M1 both reading continuously for 6 cycles.
  - Required grant order: M1, M0, M1, M0, M1, M0.
  - Each `rvalid` lands on the matching port one cycle after its grant.
- **MEM_LAT=3 read occupancy:** M0 read at cycle T; M1 request at T+1.
  - Required: `m1_gnt=0` in cycles T+1 and T+2.
  - In cycle T+3: `m0_rvalid=1` and `m1_gnt=1` together.
- **Reset mid-read, MEM_LAT=3:** assert `rst_n=0` at T+1 after an M0 read grant; release at T+2.
  - Required: no `m0_rvalid` at T+3 or later; FSM accepts a new request immediately.
- **Mixed write/read, MEM_LAT=2:** M1 write and M0 read back-to-back.
  - Required: the write occupies 1 cycle; the read is granted the next cycle; its `rvalid` arrives 2 cycles after that grant.
